// File: rtl/serial_byte_receiver_if.sv
// Link/FIFO-side signal bundle for serial_byte_receiver.
// PARITY_CHECK_EN adds parity_err_o to the bundle.
interface serial_byte_receiver_if #(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH) + 1
);
    logic             serial_in_i;
    logic             start_i;
    logic             enable_i;
    logic [7:0]       data_o;
    logic             sof_o;
    logic             valid_o;
    logic             ready_i;
    logic [CNT_W-1:0] level_o;
    logic             overflow_o;
    logic             frame_err_o;
    logic             clear_i;
    logic [1:0]       state_dbg;
`ifdef PARITY_CHECK_EN
    logic             parity_err_o;
`endif

    // Handshake: the head byte moves on any rising edge where valid_o && ready_i;
    // valid_o never depends on ready_i, and ready_i with valid_o=0 is a no-op.
    modport master (
        output serial_in_i, start_i, enable_i, ready_i, clear_i,
        input  data_o, sof_o, valid_o, level_o, overflow_o, frame_err_o, state_dbg
`ifdef PARITY_CHECK_EN
        , input parity_err_o
`endif
    );

    modport slave (
        input  serial_in_i, start_i, enable_i, ready_i, clear_i,
        output data_o, sof_o, valid_o, level_o, overflow_o, frame_err_o, state_dbg
`ifdef PARITY_CHECK_EN
        , output parity_err_o
`endif
    );
endinterface

// File: rtl/serial_byte_receiver.sv
// MSB-first serial deserialiser feeding a first-word-fall-through byte FIFO with SOF tags.
// Define PARITY_CHECK_EN for a 9th even-parity bit per byte and a sticky parity_err_o.
module serial_byte_receiver #(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    serial_byte_receiver_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } state_t;

    state_t     state;
    logic [2:0] bitcnt;
    logic [7:0] shift_reg;
    logic       sof_pending;
    logic       push_req;
    logic [7:0] push_data;
    logic       push_sof;
    logic       frame_err;
`ifdef PARITY_CHECK_EN
    logic       parity_err;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state       <= IDLE;
            bitcnt      <= 3'd0;
            shift_reg   <= 8'd0;
            sof_pending <= 1'b0;
            push_req    <= 1'b0;
            push_data   <= 8'd0;
            push_sof    <= 1'b0;
            frame_err   <= 1'b0;
`ifdef PARITY_CHECK_EN
            parity_err  <= 1'b0;
`endif
        end else begin
            push_req  <= 1'b0;
            frame_err <= 1'b0;
`ifdef PARITY_CHECK_EN
            if (bus.clear_i) parity_err <= 1'b0;
`endif
            if (bus.enable_i) begin
                if (bus.start_i) begin
                    // A start always begins a new frame; any bits collected so far are lost.
                    if ((state == SHIFT && bitcnt != 3'd0) || state == PARITY) frame_err <= 1'b1;
                    shift_reg   <= {7'd0, bus.serial_in_i};
                    bitcnt      <= 3'd1;
                    sof_pending <= 1'b1;
                    state       <= SHIFT;
                end else begin
                    case (state)
                        IDLE: ;
                        SHIFT: begin
                            bitcnt <= bitcnt + 3'd1;
                            if (bitcnt == 3'd7) begin
`ifdef PARITY_CHECK_EN
                                shift_reg   <= {shift_reg[6:0], bus.serial_in_i};
                                state       <= PARITY;
`else
                                push_req    <= 1'b1;
                                push_data   <= {shift_reg[6:0], bus.serial_in_i};
                                push_sof    <= sof_pending;
                                sof_pending <= 1'b0;
`endif
                            end else begin
                                shift_reg <= {shift_reg[6:0], bus.serial_in_i};
                            end
                        end
                        PARITY: begin
                            push_req    <= 1'b1;
                            push_data   <= shift_reg;
                            push_sof    <= sof_pending;
                            sof_pending <= 1'b0;
                            state       <= SHIFT;
`ifdef PARITY_CHECK_EN
                            if (^{shift_reg, bus.serial_in_i}) parity_err <= 1'b1;
`endif
                        end
                        default: state <= IDLE;
                    endcase
                end
            end
        end
    end

    logic [8:0]       mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             overflow;
    logic             full;
    logic             pop;
    logic             do_write;
    logic             drop;

    assign full     = (count == CNT_W'(DEPTH));
    assign pop      = (count != '0) && bus.ready_i;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign do_write = push_req && (!full || pop);
    assign drop     = push_req && full && !pop;

    always_ff @(posedge clk_i) begin
        if (do_write) mem[wr_ptr] <= {push_sof, push_data};
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_write) wr_ptr <= wr_ptr + 1'b1;
            if (pop)      rd_ptr <= rd_ptr + 1'b1;
            case ({do_write, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (drop)             overflow <= 1'b1;
            else if (bus.clear_i) overflow <= 1'b0;
        end
    end

    assign bus.valid_o             = (count != '0);
    assign {bus.sof_o, bus.data_o} = bus.valid_o ? mem[rd_ptr] : 9'd0;
    assign bus.level_o             = count;
    assign bus.overflow_o          = overflow;
    assign bus.frame_err_o         = frame_err;
    assign bus.state_dbg           = state;
`ifdef PARITY_CHECK_EN
    assign bus.parity_err_o        = parity_err;
`endif
endmodule

// File: tb/tb_serial_byte_receiver.sv
// Directed self-checking bench for serial_byte_receiver: latency, framing, FIFO full/overflow, async reset.
// Stimulus adds the parity bit automatically when PARITY_CHECK_EN is defined.
module tb_serial_byte_receiver;
  localparam int DEPTH = 4;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  serial_byte_receiver_if #(.DEPTH(DEPTH), .CNT_W(CNT_W)) bus ();

  serial_byte_receiver #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_err = 0;
  int fe_cnt = 0;
  int fe0;
  logic [8:0] exp_q[$];

  always @(negedge clk) if (bus.frame_err_o === 1'b1) fe_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive_bit(input logic b, input logic s);
    @(negedge clk);
    bus.enable_i    = 1'b1;
    bus.start_i     = s;
    bus.serial_in_i = b;
  endtask

  task automatic garbage_cycle();
    @(negedge clk);
    bus.enable_i    = 1'b0;
    bus.start_i     = 1'($urandom_range(0, 1));
    bus.serial_in_i = 1'($urandom_range(0, 1));
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    bus.enable_i    = 1'b0;
    bus.start_i     = 1'b0;
    bus.serial_in_i = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic first, input logic slow, input logic bad_par);
    for (int i = 7; i >= 0; i--) begin
      drive_bit(b[i], first && (i == 7));
      if (slow) garbage_cycle();
    end
`ifdef PARITY_CHECK_EN
    drive_bit((^b) ^ bad_par, 1'b0);
    if (slow) garbage_cycle();
`endif
    idle_cycle();
  endtask

  // Checks the head against the scoreboard, then pops it with a one-cycle ready_i.
  task automatic pop_check(input string tag);
    logic [8:0] e;
    check({tag, "_qsize"}, (exp_q.size() > 0) ? 32'd1 : 32'd0, 32'd1);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 9'd0;
    check({tag, "_valid"}, {31'd0, bus.valid_o}, 32'd1);
    check({tag, "_data"}, {24'd0, bus.data_o}, {24'd0, e[7:0]});
    check({tag, "_sof"}, {31'd0, bus.sof_o}, {31'd0, e[8]});
    bus.ready_i = 1'b1;
    @(negedge clk);
    bus.ready_i = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    bus.serial_in_i = 1'b0;
    bus.start_i     = 1'b0;
    bus.enable_i    = 1'b0;
    bus.ready_i     = 1'b0;
    bus.clear_i     = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_valid", {31'd0, bus.valid_o}, 32'd0);
    check("rst_level", {{(32-CNT_W){1'b0}}, bus.level_o}, 32'd0);
    check("rst_data", {24'd0, bus.data_o}, 32'd0);
    check("rst_state", {30'd0, bus.state_dbg}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Single byte with ready held high: latency and level 0->1->0.
    bus.ready_i = 1'b1;
    send_byte(8'hA5, 1'b1, 1'b0, 1'b0);
    check("t1_valid_before_write", {31'd0, bus.valid_o}, 32'd0);
    @(negedge clk);
    check("t1_valid", {31'd0, bus.valid_o}, 32'd1);
    check("t1_data", {24'd0, bus.data_o}, 32'hA5);
    check("t1_sof", {31'd0, bus.sof_o}, 32'd1);
    check("t1_level1", {{(32-CNT_W){1'b0}}, bus.level_o}, 32'd1);
    @(negedge clk);
    check("t1_level0", {{(32-CNT_W){1'b0}}, bus.level_o}, 32'd0);
    bus.ready_i = 1'b0;
`ifdef PARITY_CHECK_EN
    check("t1_parity_err", {31'd0, bus.parity_err_o}, 32'd0);
`endif

    // Three bytes in one frame; only the first carries sof.
    send_byte(8'h3C, 1'b1, 1'b0, 1'b0); exp_q.push_back({1'b1, 8'h3C});
    send_byte(8'hFF, 1'b0, 1'b0, 1'b0); exp_q.push_back({1'b0, 8'hFF});
    send_byte(8'h00, 1'b0, 1'b0, 1'b0); exp_q.push_back({1'b0, 8'h00});
    @(negedge clk);
    check("t2_level", {{(32-CNT_W){1'b0}}, bus.level_o}, 32'd3);
    pop_check("t2_b0");
    pop_check("t2_b1");
    pop_check("t2_b2");
    check("t2_level_empty", {{(32-CNT_W){1'b0}}, bus.level_o}, 32'd0);
    check("t2_no_frame_err", fe_cnt, 32'd0);

    // enable_i toggling with garbage on the idle cycles.
    send_byte(8'h81, 1'b1, 1'b1, 1'b0); exp_q.push_back({1'b1, 8'h81});
    @(negedge clk);
    check("t3_level", {{(32-CNT_W){1'b0}}, bus.level_o}, 32'd1);
    pop_check("t3_b0");

    // Start after five bits: one frame_err pulse, partial byte dropped.
    fe0 = fe_cnt;
    drive_bit(1'b1, 1'b1);
    drive_bit(1'b0, 1'b0);
    drive_bit(1'b1, 1'b0);
    drive_bit(1'b1, 1'b0);
    drive_bit(1'b0, 1'b0);
    send_byte(8'h42, 1'b1, 1'b0, 1'b0); exp_q.push_back({1'b1, 8'h42});
    @(negedge clk);
    check("t4_frame_err_pulses", fe_cnt - fe0, 32'd1);
    check("t4_level", {{(32-CNT_W){1'b0}}, bus.level_o}, 32'd1);
    pop_check("t4_b0");

    // DEPTH+1 bytes with ready low: last one dropped, overflow sticky until clear.
    send_byte(8'h11, 1'b1, 1'b0, 1'b0); exp_q.push_back({1'b1, 8'h11});
    send_byte(8'h22, 1'b0, 1'b0, 1'b0); exp_q.push_back({1'b0, 8'h22});
    send_byte(8'h33, 1'b0, 1'b0, 1'b0); exp_q.push_back({1'b0, 8'h33});
    send_byte(8'h44, 1'b0, 1'b0, 1'b0); exp_q.push_back({1'b0, 8'h44});
    @(negedge clk);
    check("t5_level_full", {{(32-CNT_W){1'b0}}, bus.level_o}, DEPTH);
    check("t5_ovf_pre", {31'd0, bus.overflow_o}, 32'd0);
    send_byte(8'h55, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check("t5_level_after_drop", {{(32-CNT_W){1'b0}}, bus.level_o}, DEPTH);
    check("t5_ovf_set", {31'd0, bus.overflow_o}, 32'd1);
    pop_check("t5_b0");
    pop_check("t5_b1");
    pop_check("t5_b2");
    pop_check("t5_b3");
    check("t5_empty_after", {31'd0, bus.valid_o}, 32'd0);
    check("t5_ovf_sticky", {31'd0, bus.overflow_o}, 32'd1);
    bus.clear_i = 1'b1;
    @(negedge clk);
    bus.clear_i = 1'b0;
    check("t5_ovf_cleared", {31'd0, bus.overflow_o}, 32'd0);
    check("t5_no_frame_err", fe_cnt - fe0, 32'd1);

    // Async reset in the middle of a byte with a byte already buffered.
    send_byte(8'h99, 1'b1, 1'b0, 1'b0);
    drive_bit(1'b1, 1'b1);
    drive_bit(1'b0, 1'b0);
    drive_bit(1'b1, 1'b0);
    check("t6_pre_valid", {31'd0, bus.valid_o}, 32'd1);
    #2;
    rst = 1'b1;
    bus.enable_i = 1'b0;
    bus.start_i  = 1'b0;
    #1;
    check("t6_rst_valid", {31'd0, bus.valid_o}, 32'd0);
    check("t6_rst_level", {{(32-CNT_W){1'b0}}, bus.level_o}, 32'd0);
    check("t6_rst_data", {24'd0, bus.data_o}, 32'd0);
    check("t6_rst_sof", {31'd0, bus.sof_o}, 32'd0);
    check("t6_rst_state", {30'd0, bus.state_dbg}, 32'd0);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    send_byte(8'h5A, 1'b1, 1'b0, 1'b1); exp_q.push_back({1'b1, 8'h5A});
    @(negedge clk);
    check("t6_level", {{(32-CNT_W){1'b0}}, bus.level_o}, 32'd1);
`ifdef PARITY_CHECK_EN
    check("t6_parity_err", {31'd0, bus.parity_err_o}, 32'd1);
`endif
    pop_check("t6_b0");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
